// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and vector helper for the fixed-priority interrupt controller.
package irq_pkg;

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = $clog2(NSRC);
    localparam int unsigned AW   = 10;

    localparam logic [AW-1:0] VBASE = AW'(1008);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } irq_state_e;

    // Jump vector for a source: VBASE + 4*id, wrapping at 2^AW.
    function automatic logic [AW-1:0] irq_vec_of(input logic [IDW-1:0] id);
        return VBASE + (AW'(id) << 2);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one event line, followed by a rising-edge pulse detector.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise_c
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_rise_c = r_s2 & ~r_s2_d;

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: edge-captured pending events, enable mask, irq/ack/eoi handshake.
module irq_controller
    import irq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NSRC-1:0]  i_src,
    input  logic             i_ien_we,
    input  logic [NSRC-1:0]  i_ien_in,
    output logic [NSRC-1:0]  o_ien,
    output logic [NSRC-1:0]  o_pending,
    output logic             o_irq,
    output logic [IDW-1:0]   o_irq_id,
    output logic [AW-1:0]    o_irq_vec,
    input  logic             i_ack,
    input  logic             i_eoi
);

    irq_state_e       r_state;
    irq_state_e       w_state_nxt;
    logic [NSRC-1:0]  r_ien;
    logic [NSRC-1:0]  r_pending;
    logic             r_irq;
    logic [IDW-1:0]   r_irq_id;
    logic [AW-1:0]    r_irq_vec;

    logic [NSRC-1:0]  w_rise;
    logic [NSRC-1:0]  w_eligible;
    logic [NSRC-1:0]  w_clr;
    logic [IDW-1:0]   w_win;
    logic             w_load;
    logic             w_take;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        sync_edge u_sync (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_d      (i_src[g]),
            .o_rise_c (w_rise[g])
        );
    end

    assign w_eligible = r_pending & r_ien;

    // Lowest set index wins.
    always_comb begin
        w_win = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win = IDW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = REQ;
                    w_load      = 1'b1;
                end
            end
            REQ: begin
                if (i_ack) begin
                    w_state_nxt = SERVICE;
                    w_take      = 1'b1;
                end
            end
            SERVICE: begin
                if (i_eoi) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr = w_take ? (NSRC'(1) << r_irq_id) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
            r_irq_vec <= VBASE;
            r_pending <= '0;
            r_ien     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq     <= (w_state_nxt == REQ);
            // A fresh edge on the bit being acknowledged survives the clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (i_ien_we) begin
                r_ien <= i_ien_in;
            end
            if (w_load) begin
                r_irq_id  <= w_win;
                r_irq_vec <= irq_vec_of(w_win);
            end
        end
    end

    assign o_ien     = r_ien;
    assign o_pending = r_pending;
    assign o_irq     = r_irq;
    assign o_irq_id  = r_irq_id;
    assign o_irq_vec = r_irq_vec;

endmodule
